// File: rtl/apu_pkg.sv
// Shared APU constants and types used by the channel back ends.
package apu_pkg;

   localparam logic [14:0] LFSR_SEED = 15'h7FFF;
   localparam int          LEN_FULL  = 64;

   typedef enum logic {ENV_DOWN = 1'b0, ENV_UP = 1'b1} env_dir_t;

   // NR4x bit positions
   localparam int NR44_TRIG   = 7;
   localparam int NR44_LEN_EN = 6;
   localparam int NR43_WIDTH  = 3;
   localparam int NR42_DIR    = 3;

endpackage

// File: rtl/volume_envelope.sv
// NR42 latch plus volume envelope; shared with the square channels.
module volume_envelope
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_en,
   input  logic [7:0] new_data,
   input  logic       nr42_write,
   input  logic       trigger,
   input  logic       envelope_tick,
   input  logic       enable,
   output logic [7:0] nr42,
   output logic [3:0] volume,
   output logic       dac_on
);

   logic [2:0] timer;
   logic [2:0] period;
   env_dir_t   dir;

   assign period = nr42[2:0];
   assign dir    = env_dir_t'(nr42[NR42_DIR]);
   assign dac_on = (nr42[7:3] != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         nr42   <= 8'h00;
         volume <= 4'h0;
         timer  <= 3'd0;
      end else begin
         if (cpu_en && nr42_write)
            nr42 <= new_data;
         if (trigger) begin
            volume <= nr42[7:4];
            timer  <= period;
         end else if (envelope_tick && enable && period != 3'd0) begin
            // a timer already at 0 (period written after trigger) expires immediately
            if (timer <= 3'd1) begin
               timer <= period;
               if (dir == ENV_UP && volume != 4'hF)
                  volume <= volume + 4'd1;
               else if (dir == ENV_DOWN && volume != 4'h0)
                  volume <= volume - 4'd1;
            end else begin
               timer <= timer - 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/noise_lfsr_channel.sv
// CH4 back end: LFSR, trigger, length counter and amplitude gating.
module noise_lfsr_channel
   import apu_pkg::*;
#(
   parameter int LEN_BITS = $clog2(LEN_FULL)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_clk_en,
   input  logic       cpu_en,
   input  logic       next_step,
   input  logic       length_tick,
   input  logic       envelope_tick,
   input  logic [7:0] new_data,
   input  logic       nr41_write,
   input  logic       nr42_write,
   input  logic       nr43_write,
   input  logic       nr44_write,
   output logic [7:0] nr42,
   output logic       length_en,
   output logic       active,
   output logic [3:0] amplitude
);

   localparam logic [LEN_BITS:0] LEN_MAX = {1'b1, {LEN_BITS{1'b0}}};

   logic [14:0]       lfsr;
   logic [14:0]       lfsr_next;
   logic              width_mode;
   logic [LEN_BITS:0] len_cnt;
   logic [3:0]        volume;
   logic              dac_on;
   logic              trigger;
   logic              nr41_wr;
   logic              len_dec;
   logic              fb;

   assign trigger = cpu_en & nr44_write & new_data[NR44_TRIG];
   assign nr41_wr = cpu_en & nr41_write;
   // trigger and NR41 writes both pre-empt a same-cycle length tick
   assign len_dec = length_tick & length_en & (len_cnt != '0) & ~trigger & ~nr41_wr;

   assign fb = lfsr[0] ^ lfsr[1];
   always_comb begin
      lfsr_next = {fb, lfsr[14:1]};
      if (width_mode)
         lfsr_next[6] = fb;
   end

   assign amplitude = (active & ~lfsr[0]) ? volume : 4'h0;

   volume_envelope u_env (
      .clk           (clk),
      .reset         (reset),
      .cpu_en        (cpu_en),
      .new_data      (new_data),
      .nr42_write    (nr42_write),
      .trigger       (trigger),
      .envelope_tick (envelope_tick),
      .enable        (active),
      .nr42          (nr42),
      .volume        (volume),
      .dac_on        (dac_on)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= LFSR_SEED;
         width_mode <= 1'b0;
         len_cnt    <= '0;
         length_en  <= 1'b0;
         active     <= 1'b0;
      end else begin
         if (cpu_en && nr43_write)
            width_mode <= new_data[NR43_WIDTH];
         if (cpu_en && nr44_write)
            length_en <= new_data[NR44_LEN_EN];

         if (trigger)
            lfsr <= LFSR_SEED;
         else if (slow_clk_en && next_step && active)
            lfsr <= lfsr_next;

         if (nr41_wr)
            len_cnt <= LEN_MAX - {1'b0, new_data[LEN_BITS-1:0]};
         else if (trigger) begin
            if (len_cnt == '0)
               len_cnt <= LEN_MAX;
         end else if (len_dec)
            len_cnt <= len_cnt - 1'b1;

         if (trigger)
            active <= dac_on;
         else if (cpu_en && nr42_write && new_data[7:3] == 5'd0)
            active <= 1'b0;
         else if (len_dec && len_cnt == {{LEN_BITS{1'b0}}, 1'b1})
            active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noise_lfsr_channel.sv
// Directed bench for the CH4 noise back end.
module tb_noise_lfsr_channel;
   import apu_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       slow_clk_en = 1'b0, cpu_en = 1'b0, next_step = 1'b0;
   logic       length_tick = 1'b0, envelope_tick = 1'b0;
   logic [7:0] new_data = 8'h00;
   logic       nr41_write = 1'b0, nr42_write = 1'b0, nr43_write = 1'b0, nr44_write = 1'b0;
   logic [7:0] nr42;
   logic       length_en, active;
   logic [3:0] amplitude;

   int checks = 0;
   int errors = 0;

   noise_lfsr_channel dut (
      .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .cpu_en(cpu_en),
      .next_step(next_step), .length_tick(length_tick), .envelope_tick(envelope_tick),
      .new_data(new_data), .nr41_write(nr41_write), .nr42_write(nr42_write),
      .nr43_write(nr43_write), .nr44_write(nr44_write), .nr42(nr42),
      .length_en(length_en), .active(active), .amplitude(amplitude)
   );

   always #5 clk = ~clk;

   // wr = {nr44, nr43, nr42, nr41}
   typedef struct {
      string      name;
      logic       cpu;
      logic [3:0] wr;
      logic [7:0] data;
      logic       step;
      logic       e_act;
      logic [3:0] e_amp;
      logic [7:0] e_nr42;
      logic       e_len;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic [3:0] w, input logic [7:0] d,
                        input logic st, input logic lt, input logic et);
      cpu_en = c; {nr44_write, nr43_write, nr42_write, nr41_write} = w; new_data = d;
      slow_clk_en = st; next_step = st; length_tick = lt; envelope_tick = et;
      @(posedge clk); #1;
      cpu_en = 1'b0; {nr44_write, nr43_write, nr42_write, nr41_write} = 4'b0; new_data = 8'h00;
      slow_clk_en = 1'b0; next_step = 1'b0; length_tick = 1'b0; envelope_tick = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic logic [14:0] lstep(input logic [14:0] l, input logic w);
      logic       x;
      logic [14:0] n;
      x = l[0] ^ l[1];
      n = {x, l[14:1]};
      if (w) n[6] = x;
      return n;
   endfunction

   function automatic logic [3:0] amp_of(input logic [14:0] l, input logic [3:0] v);
      return l[0] ? 4'h0 : v;
   endfunction

   logic [14:0] m;
   logic [3:0]  ev;

   initial begin
      vecs[0] = '{"nr42_wr",        1, 4'b0010, 8'hF0, 0, 0, 4'h0, 8'hF0, 0};
      vecs[1] = '{"trigger",        1, 4'b1000, 8'h80, 0, 1, 4'h0, 8'hF0, 0};
      vecs[2] = '{"step_from_seed", 1, 4'b0000, 8'h00, 1, 1, 4'h0, 8'hF0, 0};
      vecs[3] = '{"cpu_en_gate",    0, 4'b0010, 8'h00, 0, 1, 4'h0, 8'hF0, 0};
      vecs[4] = '{"dac_off_write",  1, 4'b0010, 8'h00, 0, 0, 4'h0, 8'h00, 0};
      vecs[5] = '{"trig_dac_off",   1, 4'b1000, 8'h80, 0, 0, 4'h0, 8'h00, 0};
      vecs[6] = '{"nr42_dac_on",    1, 4'b0010, 8'h08, 0, 0, 4'h0, 8'h08, 0};
      vecs[7] = '{"trig_len_en",    1, 4'b1000, 8'hC0, 0, 1, 4'h0, 8'h08, 1};
      vecs[8] = '{"len_en_no_trig", 1, 4'b1000, 8'h40, 0, 1, 4'h0, 8'h08, 1};
      vecs[9] = '{"len_en_clear",   1, 4'b1000, 8'h00, 0, 1, 4'h0, 8'h08, 0};

      do_reset();
      chk("rst_nr42", nr42, 8'h00);
      chk("rst_active", {7'h0, active}, 8'h00);
      chk("rst_amp", {4'h0, amplitude}, 8'h00);
      chk("rst_len_en", {7'h0, length_en}, 8'h00);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].cpu, vecs[i].wr, vecs[i].data, vecs[i].step, 1'b0, 1'b0);
         chk({vecs[i].name, "_act"}, {7'h0, active}, {7'h0, vecs[i].e_act});
         chk({vecs[i].name, "_amp"}, {4'h0, amplitude}, {4'h0, vecs[i].e_amp});
         chk({vecs[i].name, "_nr42"}, nr42, vecs[i].e_nr42);
         chk({vecs[i].name, "_len_en"}, {7'h0, length_en}, {7'h0, vecs[i].e_len});
      end

      // 15-bit LFSR with a gated (slow_clk_en low) step in the middle
      do_reset();
      drive(1, 4'b0010, 8'hF0, 0, 0, 0);
      drive(1, 4'b1000, 8'h80, 0, 0, 0);
      m = LFSR_SEED;
      for (int i = 0; i < 32; i++) begin
         if (i == 20) begin
            next_step = 1'b1; @(posedge clk); #1; next_step = 1'b0;
         end
         drive(1, 4'b0000, 8'h00, 1, 0, 0);
         m = lstep(m, 1'b0);
         chk("lfsr_w15_amp", {4'h0, amplitude}, {4'h0, amp_of(m, 4'hF)});
      end

      // 7-bit mode, two full periods
      do_reset();
      drive(1, 4'b0010, 8'hF0, 0, 0, 0);
      drive(1, 4'b0100, 8'h08, 0, 0, 0);
      drive(1, 4'b1000, 8'h80, 0, 0, 0);
      m = LFSR_SEED;
      for (int i = 0; i < 254; i++) begin
         drive(1, 4'b0000, 8'h00, 1, 0, 0);
         m = lstep(m, 1'b1);
         chk("lfsr_w7_amp", {4'h0, amplitude}, {4'h0, amp_of(m, 4'hF)});
      end

      // length counter
      do_reset();
      drive(1, 4'b0010, 8'hF0, 0, 0, 0);
      drive(1, 4'b0001, 8'h3E, 0, 0, 0);
      drive(1, 4'b1000, 8'hC0, 0, 0, 0);
      chk("len2_start", {7'h0, active}, 8'h01);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("len2_tick1", {7'h0, active}, 8'h01);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("len2_tick2", {7'h0, active}, 8'h00);
      chk("len2_amp", {4'h0, amplitude}, 8'h00);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("len0_hold", {7'h0, active}, 8'h00);
      drive(1, 4'b1000, 8'hC0, 0, 1, 0);
      chk("trig_tick_reload", {7'h0, active}, 8'h01);
      for (int i = 0; i < 63; i++) begin
         drive(1, 4'b0000, 8'h00, 0, 1, 0);
         chk("len64_run", {7'h0, active}, 8'h01);
      end
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("len64_end", {7'h0, active}, 8'h00);
      drive(1, 4'b0001, 8'h3E, 0, 0, 0);
      drive(1, 4'b1000, 8'hC0, 0, 1, 0);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("trig_beats_tick", {7'h0, active}, 8'h01);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("trig_beats_tick_end", {7'h0, active}, 8'h00);
      drive(1, 4'b1000, 8'hC0, 0, 0, 0);
      drive(1, 4'b0001, 8'h3F, 0, 1, 0);
      chk("nr41_beats_tick", {7'h0, active}, 8'h01);
      drive(1, 4'b0000, 8'h00, 0, 1, 0);
      chk("nr41_len1_end", {7'h0, active}, 8'h00);

      // envelope up with saturation at 15
      do_reset();
      drive(1, 4'b0010, 8'h1B, 0, 0, 0);
      drive(1, 4'b1000, 8'h80, 0, 0, 0);
      m = LFSR_SEED;
      for (int i = 0; i < 15; i++) begin
         drive(1, 4'b0000, 8'h00, 1, 0, 0);
         m = lstep(m, 1'b0);
      end
      chk("env_start", {4'h0, amplitude}, {4'h0, amp_of(m, 4'h1)});
      for (int n = 1; n <= 48; n++) begin
         drive(1, 4'b0000, 8'h00, 0, 0, 1);
         ev = (1 + n / 3 > 15) ? 4'hF : 4'(1 + n / 3);
         chk("env_up", {4'h0, amplitude}, {4'h0, amp_of(m, ev)});
      end

      // envelope down, trigger beats envelope tick, saturation at 0
      drive(1, 4'b0010, 8'h21, 0, 0, 0);
      drive(1, 4'b1000, 8'h80, 0, 0, 1);
      m = LFSR_SEED;
      for (int i = 0; i < 15; i++) begin
         drive(1, 4'b0000, 8'h00, 1, 0, 0);
         m = lstep(m, 1'b0);
      end
      chk("env_dn_start", {4'h0, amplitude}, {4'h0, amp_of(m, 4'h2)});
      drive(1, 4'b0000, 8'h00, 0, 0, 1);
      chk("env_dn_1", {4'h0, amplitude}, {4'h0, amp_of(m, 4'h1)});
      drive(1, 4'b0000, 8'h00, 0, 0, 1);
      drive(1, 4'b0000, 8'h00, 0, 0, 1);
      chk("env_dn_sat0", {4'h0, amplitude}, 8'h00);
      chk("env_dn_active", {7'h0, active}, 8'h01);

      // reset mid-operation overrides pending writes and ticks
      drive(1, 4'b1000, 8'hC0, 0, 0, 0);
      reset = 1'b1;
      drive(1, 4'b0010, 8'hF0, 0, 1, 1);
      reset = 1'b0;
      chk("midrst_nr42", nr42, 8'h00);
      chk("midrst_active", {7'h0, active}, 8'h00);
      chk("midrst_amp", {4'h0, amplitude}, 8'h00);
      chk("midrst_len_en", {7'h0, length_en}, 8'h00);
      drive(1, 4'b1000, 8'h80, 0, 0, 0);
      chk("midrst_trig_dac_off", {7'h0, active}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
